regfile_mp: RTL and testbench

- Parametrised successor to the single-cycle processor's 32x32, 2-read/1-write register file.
- Adds configurable width, depth, read-port count and write-port count.
- Adds a per-register busy scoreboard, so later multi-cycle or pipelined cores can track in-flight writes.
- Instantiated by the top-level wrapper in place of the fixed register file; all read data is combinational and all state updates on the clock edge.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wr_sel.sv | 24 ++
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, port-slicing helper and the hardwired-zero register index for regfile_mp.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;
    localparam int ZERO_REG   = 0;
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/regfile_wr_sel.sv
// regfile_wr_sel: per-register one-hot winning write port and write strobe; highest-index port wins, register 0 never selected.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic [NUM_WR-1:0]             we,
    input  logic [NUM_WR*ADDR_W-1:0]      waddr,
    output logic [DEPTH-1:0][NUM_WR-1:0]  sel,
    output logic [DEPTH-1:0]              wr
);
    always_comb begin
        sel = '0;
        wr  = '0;
        for (int r = ZERO_REG + 1; r < DEPTH; r++) begin
            for (int k = 0; k < NUM_WR; k++)
                if (we[k] && waddr[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r))
                    sel[r] = NUM_WR'(1) << k;
            wr[r] = |sel[r];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        ctrl_writeEnable,
    input  logic [NUM_WR*ADDR_W-1:0] ctrl_writeReg,
    input  logic [NUM_WR*DATA_W-1:0] data_writeReg,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_set_reg,
    output logic [NUM_RD-1:0]        busy_rd,
    output logic                     busy_any
);
    logic [NUM_WR-1:0]             we;
    logic [DATA_W-1:0]             mem [DEPTH];
    logic [DEPTH-1:0][NUM_WR-1:0]  sel;
    logic [DEPTH-1:0][DATA_W-1:0]  wd;
    logic [DEPTH-1:0]              wr, busy, busy_nxt;
    logic [ADDR_W-1:0]             ra;

    // Gating enables in reset keeps the bypass path from leaking write data while held.
    assign we = reset ? ctrl_writeEnable : '0;

    regfile_wr_sel #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_wr_sel (
        .we    (we),
        .waddr (ctrl_writeReg),
        .sel   (sel),
        .wr    (wr)
    );

    // Set beats clear: a new producer overrides the retiring write.
    always_comb begin
        wd       = '0;
        busy_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int k = 0; k < NUM_WR; k++)
                if (sel[r][k]) wd[r] = data_writeReg[slice_lo(k, DATA_W) +: DATA_W];
            busy_nxt[r] = (busy[r] & ~wr[r]) |
                          (reset && busy_set && r != ZERO_REG && busy_set_reg == ADDR_W'(r));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else begin
            busy <= busy_nxt;
            for (int r = 0; r < DEPTH; r++) if (wr[r]) mem[r] <= wd[r];
        end
    end

    always_comb begin
        data_readReg = '0;
        busy_rd      = '0;
        ra           = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra = ctrl_readReg[slice_lo(j, ADDR_W) +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
            data_readReg[slice_lo(j, DATA_W) +: DATA_W] = wr[ra] ? wd[ra] : mem[ra];
            busy_rd[j] = wr[ra] ? busy_nxt[ra] : busy[ra];
`else
            data_readReg[slice_lo(j, DATA_W) +: DATA_W] = mem[ra];
            busy_rd[j] = busy[ra];
`endif
        end
    end

    assign busy_any = |busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp (default build and a narrow 16x8, 4R/1W instance).
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  wen = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        bset = 1'b0;
    logic [4:0]  bsreg = '0;
    logic [1:0]  brd;
    logic        bany;

    logic [0:0]  s_wen = '0;
    logic [2:0]  s_waddr = '0;
    logic [15:0] s_wdata = '0;
    logic [11:0] s_raddr = '0;
    logic [63:0] s_rdata;
    logic [3:0]  s_brd;
    logic        s_bany;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    regfile_mp dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(wen), .ctrl_writeReg(waddr), .data_writeReg(wdata),
        .ctrl_readReg(raddr), .data_readReg(rdata),
        .busy_set(bset), .busy_set_reg(bsreg), .busy_rd(brd), .busy_any(bany)
    );

    regfile_mp #(.DATA_W(16), .DEPTH(8), .NUM_RD(4), .NUM_WR(1)) dut_s (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(s_wen), .ctrl_writeReg(s_waddr), .data_writeReg(s_wdata),
        .ctrl_readReg(s_raddr), .data_readReg(s_rdata),
        .busy_set(1'b0), .busy_set_reg(3'd0), .busy_rd(s_brd), .busy_any(s_bany)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        wen[k] = 1'b1;
        waddr[k*5 +: 5] = a;
        wdata[k*32 +: 32] = d;
    endtask

    task automatic rd(input int j, input logic [4:0] a);
        raddr[j*5 +: 5] = a;
    endtask

    task automatic idle();
        wen  = '0;
        bset = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        rd(0, 5);
        push("rst_rd", 32'h0);
        push("rst_busy", 32'h0);
        chk(rdata[31:0]);
        chk({31'b0, bany});
        @(negedge clock);
        reset = 1'b1;
        tick();
        // Write r5 and mark r4 busy, then drop reset mid-cycle.
        wr(0, 5, 32'hDEADBEEF);
        bset = 1'b1;
        bsreg = 5'd4;
        push("wr_r5", 32'hDEADBEEF);
        push("busy_r4", 32'h1);
        tick();
        idle();
        chk(rdata[31:0]);
        chk({31'b0, bany});
        #3 reset = 1'b0;
        #1;
        push("rst_mid_rd", 32'h0);
        push("rst_mid_busy", 32'h0);
        chk(rdata[31:0]);
        chk({31'b0, bany});
        #1 reset = 1'b1;
        tick();
        // r0 is hardwired zero and never busy.
        wr(0, 0, 32'h12345678);
        wr(1, 0, 32'h12345678);
        bset = 1'b1;
        bsreg = 5'd0;
        rd(0, 0);
        rd(1, 0);
        push("r0_p0", 32'h0);
        push("r0_p1", 32'h0);
        push("r0_busy", 32'h0);
        tick();
        idle();
        chk(rdata[31:0]);
        chk(rdata[63:32]);
        chk({31'b0, bany});
        // Collision: port 1 wins.
        wr(0, 7, 32'h1111);
        wr(1, 7, 32'h2222);
        rd(0, 7);
        rd(1, 7);
        push("coll_p0", 32'h2222);
        push("coll_p1", 32'h2222);
        push("coll_busy", 32'h0);
        tick();
        idle();
        chk(rdata[31:0]);
        chk(rdata[63:32]);
        chk({31'b0, bany});
        // Scoreboard set, clear, set-wins.
        bset = 1'b1;
        bsreg = 5'd9;
        rd(1, 9);
        push("sb_pre", 32'h0);
        #1 chk({31'b0, brd[1]});
        push("sb_set", 32'h1);
        push("sb_any", 32'h1);
        tick();
        idle();
        chk({31'b0, brd[1]});
        chk({31'b0, bany});
        wr(0, 9, 32'hA5A5);
        push("sb_clr", 32'h0);
        push("sb_val", 32'hA5A5);
        push("sb_any0", 32'h0);
        tick();
        idle();
        chk({31'b0, brd[1]});
        chk(rdata[63:32]);
        chk({31'b0, bany});
        wr(1, 9, 32'h5A5A);
        bset = 1'b1;
        bsreg = 5'd9;
        push("sb_keep", 32'h1);
        push("sb_keep_val", 32'h5A5A);
        tick();
        idle();
        chk({31'b0, brd[1]});
        chk(rdata[63:32]);
        // Bypass behaviour depends on build.
        wr(0, 3, 32'hCAFEF00D);
        rd(0, 3);
`ifdef REGFILE_MP_BYPASS_EN
        push("byp_pre", 32'hCAFEF00D);
`else
        push("byp_pre", 32'h0);
`endif
        #1 chk(rdata[31:0]);
        push("byp_post", 32'hCAFEF00D);
        tick();
        idle();
        chk(rdata[31:0]);
        // Narrow instance: fill r1..r7, read back on four ports.
        for (int i = 1; i < 8; i++) begin
            s_wen = 1'b1;
            s_waddr = 3'(i);
            s_wdata = 16'(i * 16'h0101);
            tick();
        end
        s_wen = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                int a;
                a = (r * 4 + j + 1) % 8;
                s_raddr[j*3 +: 3] = 3'(a);
                push($sformatf("sweep_p%0d_r%0d", j, a), 32'(a * 16'h0101));
            end
            #1;
            for (int j = 0; j < 4; j++) chk({16'b0, s_rdata[j*16 +: 16]});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
